zb_depth_test: RTL and testbench

- Downstream neighbour of the Bresenham line FSM. It consumes one rasterised pixel (x, y, z, colour) per four-phase req/ack transaction on the line FSM's output side.
- It performs the Z-buffer read-compare-write against a single-port synchronous depth/colour RAM, and provides a full-buffer clear mode for the start of a frame.

---
 rtl/zb_pkg.sv | 41 ++++
 rtl/zb_depth_test_if.sv | 41 ++++
 rtl/zb_addr_gen.sv | 28 ++
 rtl/zb_depth_test.sv | 188 ++++++++++++++++++
 tb/tb_zb_depth_test.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/zb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : zb_pkg
// Brief    : Shared types and default constants for the Z-buffer depth stage.
// Revision : 1.0 - initial release
// ============================================================================
package zb_pkg;

    localparam int c_X_W      = 10;
    localparam int c_Y_W      = 9;
    localparam int c_Z_W      = 16;
    localparam int c_C_W      = 16;
    localparam int c_SCREEN_W = 640;
    localparam int c_SCREEN_H = 480;
    localparam int c_ADDR_W   = 19;

    localparam logic [c_Z_W-1:0] c_Z_FAR = '1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_CMP   = 3'd2,
        ST_WR    = 3'd3,
        ST_REL   = 3'd4,
        ST_CLEAR = 3'd5,
        ST_DONE  = 3'd6
    } zb_state_t;

    typedef struct packed {
        logic [c_X_W-1:0] x;
        logic [c_Y_W-1:0] y;
        logic [c_Z_W-1:0] z;
        logic [c_C_W-1:0] c;
    } zb_pixel_t;

    function automatic int zb_pixels(input int w, input int h);
        return w * h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/zb_depth_test_if.sv
`default_nettype none
// ============================================================================
// Module   : zb_depth_test_if
// Brief    : Pixel req/ack handshake plus single-port depth/colour RAM bus.
// Revision : 1.0 - initial release
// ============================================================================
interface zb_depth_test_if #(
    parameter int X_W    = 10,
    parameter int Y_W    = 9,
    parameter int Z_W    = 16,
    parameter int C_W    = 16,
    parameter int ADDR_W = 19
) ();

    logic                 req_in;
    logic                 ack_in;
    logic [X_W-1:0]       x_in;
    logic [Y_W-1:0]       y_in;
    logic [Z_W-1:0]       z_in;
    logic [C_W-1:0]       c_in;

    logic                 mem_en;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_addr;
    logic [Z_W+C_W-1:0]   mem_wdata;
    logic [Z_W+C_W-1:0]   mem_rdata;

    // Line FSM / RAM side
    modport master (
        output req_in, x_in, y_in, z_in, c_in, mem_rdata,
        input  ack_in, mem_en, mem_we, mem_addr, mem_wdata
    );

    // Depth-test stage side
    modport slave (
        input  req_in, x_in, y_in, z_in, c_in, mem_rdata,
        output ack_in, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/zb_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : zb_addr_gen
// Brief    : Linear framebuffer address y*SCREEN_W + x and on-screen check.
// Revision : 1.0 - initial release
// ============================================================================
module zb_addr_gen
    import zb_pkg::*;
#(
    parameter int X_W      = c_X_W,
    parameter int Y_W      = c_Y_W,
    parameter int ADDR_W   = c_ADDR_W,
    parameter int SCREEN_W = c_SCREEN_W,
    parameter int SCREEN_H = c_SCREEN_H
) (
    input  wire logic [X_W-1:0]    x,
    input  wire logic [Y_W-1:0]    y,
    output logic      [ADDR_W-1:0] addr,
    output logic                   in_range
);

    localparam logic [ADDR_W-1:0] c_LINE = ADDR_W'(SCREEN_W);

    assign addr     = ADDR_W'(y) * c_LINE + ADDR_W'(x);
    assign in_range = (32'(x) < 32'(SCREEN_W)) && (32'(y) < 32'(SCREEN_H));

endmodule
`default_nettype wire

// File: rtl/zb_depth_test.sv
`default_nettype none
// ============================================================================
// Module   : zb_depth_test
// Brief    : Z-buffer read-compare-write stage with full-buffer clear mode.
// Revision : 1.0 - initial release
// ============================================================================
module zb_depth_test
    import zb_pkg::*;
#(
    parameter int          X_W      = c_X_W,
    parameter int          Y_W      = c_Y_W,
    parameter int          Z_W      = c_Z_W,
    parameter int          C_W      = c_C_W,
    parameter int          SCREEN_W = c_SCREEN_W,
    parameter int          SCREEN_H = c_SCREEN_H,
    parameter int          ADDR_W   = c_ADDR_W,
    parameter logic [C_W-1:0] BG_COLOR = '0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    zb_depth_test_if.slave    bus,
    input  wire logic         clr_req,
    output logic              clr_done,
    output logic              busy,
    output logic [15:0]       pass_cnt,
    output logic [15:0]       fail_cnt
);

    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(zb_pixels(SCREEN_W, SCREEN_H) - 1);

    zb_state_t          r_state;
    logic [X_W-1:0]     r_x;
    logic [Y_W-1:0]     r_y;
    logic [Z_W-1:0]     r_z;
    logic [C_W-1:0]     r_c;
    logic [ADDR_W-1:0]  r_clr_cnt;
    logic               r_ack;
    logic               r_busy;
    logic               r_done;
    logic [15:0]        r_pass;
    logic [15:0]        r_fail;

    logic [ADDR_W-1:0]  w_addr;
    logic               w_in_range;
    logic [Z_W-1:0]     w_stored_z;
    logic               w_mem_en;
    logic               w_mem_we;
    logic [ADDR_W-1:0]  w_mem_addr;
    logic [Z_W+C_W-1:0] w_mem_wdata;

    zb_addr_gen #(
        .X_W      (X_W),
        .Y_W      (Y_W),
        .ADDR_W   (ADDR_W),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_addr_gen (
        .x        (r_x),
        .y        (r_y),
        .addr     (w_addr),
        .in_range (w_in_range)
    );

    assign w_stored_z = bus.mem_rdata[Z_W+C_W-1:C_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_z       <= '0;
            r_c       <= '0;
            r_clr_cnt <= '0;
            r_ack     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= '0;
            r_fail    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clr_req) begin
                        r_state   <= ST_CLEAR;
                        r_clr_cnt <= '0;
                        r_busy    <= 1'b1;
                    end else if (bus.req_in) begin
                        r_x     <= bus.x_in;
                        r_y     <= bus.y_in;
                        r_z     <= bus.z_in;
                        r_c     <= bus.c_in;
                        r_ack   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (w_in_range) begin
                        r_state <= ST_CMP;
                    end else begin
                        r_fail  <= r_fail + 16'd1;
                        r_state <= ST_REL;
                    end
                end
                ST_CMP: begin
                    // Strict compare: on a depth tie the earlier pixel keeps the spot
                    if (r_z < w_stored_z) begin
                        r_state <= ST_WR;
                    end else begin
                        r_fail  <= r_fail + 16'd1;
                        r_state <= ST_REL;
                    end
                end
                ST_WR: begin
                    r_pass  <= r_pass + 16'd1;
                    r_state <= ST_REL;
                end
                ST_REL: begin
                    if (!bus.req_in) begin
                        r_ack   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == c_LAST) begin
                        r_done  <= 1'b1;
                        r_pass  <= '0;
                        r_fail  <= '0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM strobes decode only from registered state, so they settle once per cycle
    always_comb begin
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        case (r_state)
            ST_RD: begin
                if (w_in_range) begin
                    w_mem_en   = 1'b1;
                    w_mem_addr = w_addr;
                end
            end
            ST_WR: begin
                w_mem_en    = 1'b1;
                w_mem_we    = 1'b1;
                w_mem_addr  = w_addr;
                w_mem_wdata = {r_z, r_c};
            end
            ST_CLEAR: begin
                w_mem_en    = 1'b1;
                w_mem_we    = 1'b1;
                w_mem_addr  = r_clr_cnt;
                w_mem_wdata = {{Z_W{1'b1}}, BG_COLOR};
            end
            default: ;
        endcase
    end

    assign bus.ack_in    = r_ack;
    assign bus.mem_en    = w_mem_en;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign clr_done      = r_done;
    assign busy          = r_busy;
    assign pass_cnt      = r_pass;
    assign fail_cnt      = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_zb_depth_test.sv
`default_nettype none
// ============================================================================
// Module   : tb_zb_depth_test
// Brief    : Scoreboard bench for zb_depth_test on an 8x4 screen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zb_depth_test;
    import zb_pkg::*;

    localparam int c_SW   = 8;
    localparam int c_SH   = 4;
    localparam int c_NPIX = c_SW * c_SH;
    localparam logic [31:0] c_CLR_WORD = {c_Z_FAR, 16'h0000};

    typedef struct packed {
        logic [18:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_req;
    logic        clr_done;
    logic        busy;
    logic [15:0] pass_cnt;
    logic [15:0] fail_cnt;

    zb_depth_test_if #(.X_W(10), .Y_W(9), .Z_W(16), .C_W(16), .ADDR_W(19)) bus ();

    zb_depth_test #(
        .X_W(10), .Y_W(9), .Z_W(16), .C_W(16),
        .SCREEN_W(c_SW), .SCREEN_H(c_SH), .ADDR_W(19), .BG_COLOR(16'h0000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .clr_req  (clr_req),
        .clr_done (clr_done),
        .busy     (busy),
        .pass_cnt (pass_cnt),
        .fail_cnt (fail_cnt)
    );

    always #5 clk = ~clk;

    // Environment RAM: registered read, valid the cycle after the access
    logic [31:0] ram [c_NPIX];
    always @(posedge clk) begin
        if (bus.mem_en === 1'b1) begin
            if (bus.mem_we) ram[bus.mem_addr[4:0]] <= bus.mem_wdata;
            else            bus.mem_rdata <= ram[bus.mem_addr[4:0]];
        end
    end

    // Reference model and scoreboard state
    logic [31:0] model_mem [c_NPIX];
    logic [15:0] m_pass = '0;
    logic [15:0] m_fail = '0;
    int          exp_rd[$];
    wr_t         exp_wr[$];
    int          checks = 0;
    int          errors = 0;
    int          done_pulses = 0;
    int          exp_done = 0;
    int          rd_exp;
    wr_t         wr_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every RAM access must match the next expected one in order
    always @(negedge clk) begin
        if (bus.mem_en === 1'b1) begin
            if (bus.mem_we) begin
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none expected", bus.mem_addr, bus.mem_wdata);
                end else begin
                    wr_exp = exp_wr.pop_front();
                    check("write", {13'h0, bus.mem_addr, bus.mem_wdata}, {13'h0, wr_exp});
                end
                if (bus.mem_wdata == c_CLR_WORD) check("ack_during_clear", 64'(bus.ack_in), 64'h0);
            end else begin
                if (exp_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read: addr %0h, none expected", bus.mem_addr);
                end else begin
                    rd_exp = exp_rd.pop_front();
                    check("read_addr", 64'(bus.mem_addr), 64'(rd_exp));
                end
            end
        end
        if (clr_done === 1'b1) done_pulses++;
    end

    function automatic zb_pixel_t mk_pix(input int x, input int y, input int z, input int c);
        zb_pixel_t p;
        p.x = 10'(x); p.y = 9'(y); p.z = 16'(z); p.c = 16'(c);
        return p;
    endfunction

    // Behavioural depth-test rule on the modelled frame buffer
    task automatic expect_pixel(input zb_pixel_t p);
        int a;
        if (int'(p.x) >= c_SW || int'(p.y) >= c_SH) begin
            m_fail++;
        end else begin
            a = int'(p.y) * c_SW + int'(p.x);
            exp_rd.push_back(a);
            if (p.z < model_mem[a][31:16]) begin
                exp_wr.push_back({19'(a), p.z, p.c});
                model_mem[a] = {p.z, p.c};
                m_pass++;
            end else begin
                m_fail++;
            end
        end
    endtask

    task automatic expect_clear();
        for (int i = 0; i < c_NPIX; i++) begin
            exp_wr.push_back({19'(i), c_CLR_WORD});
            model_mem[i] = c_CLR_WORD;
        end
        m_pass = '0;
        m_fail = '0;
        exp_done++;
    endtask

    task automatic drive_pixel(input zb_pixel_t p);
        bus.x_in = p.x; bus.y_in = p.y; bus.z_in = p.z; bus.c_in = p.c;
    endtask

    task automatic wait_ack(input logic lvl, input int budget, output int cyc);
        cyc = 0;
        while (bus.ack_in !== lvl && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (bus.ack_in !== lvl) cyc = -1;
    endtask

    task automatic wait_done(input int budget);
        int cyc = 0;
        int ack_hi = 0;
        while (clr_done !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bus.ack_in === 1'b1) ack_hi++;
        end
        check("clr_done_seen", 64'(clr_done), 64'h1);
        check("no_ack_in_clear", 64'(ack_hi), 64'h0);
        @(negedge clk);
        check("clr_done_one_cycle", 64'(clr_done), 64'h0);
        check("busy_after_done", 64'(busy), 64'h0);
    endtask

    // Four-phase handshake; hold is cycles req stays high after ack is seen
    task automatic finish_handshake(input int hold);
        int cyc;
        wait_ack(1'b1, 10, cyc);
        check("ack_rise_timeout", 64'(cyc < 0), 64'h0);
        repeat (hold) @(negedge clk);
        bus.req_in = 1'b0;
        wait_ack(1'b0, 10, cyc);
        if (hold >= 3) check("ack_fall_latency", 64'(cyc), 64'd1);
        else           check("ack_fall_timeout", 64'(cyc < 0), 64'h0);
        check("pass_cnt", 64'(pass_cnt), 64'(m_pass));
        check("fail_cnt", 64'(fail_cnt), 64'(m_fail));
        check("busy_idle", 64'(busy), 64'h0);
    endtask

    task automatic run_pixel(input zb_pixel_t p, input int hold);
        drive_pixel(p);
        expect_pixel(p);
        bus.req_in = 1'b1;
        finish_handshake(hold);
    endtask

    task automatic do_clear();
        expect_clear();
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        wait_done(80);
        check("clear_writes_all", 64'(exp_wr.size()), 64'h0);
        check("pass_after_clear", 64'(pass_cnt), 64'h0);
        check("fail_after_clear", 64'(fail_cnt), 64'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int mism;
        rst = 1'b0; clr_req = 1'b0; bus.req_in = 1'b0;
        drive_pixel(mk_pix(0, 0, 0, 0));
        repeat (3) @(negedge clk);
        check("rst_ack", 64'(bus.ack_in), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_clr_done", 64'(clr_done), 64'h0);
        check("rst_mem_en_we", {62'h0, bus.mem_en, bus.mem_we}, 64'h0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'h0);
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'h0);
        check("rst_counters", {32'h0, pass_cnt, fail_cnt}, 64'h0);
        rst = 1'b1;
        @(negedge clk);

        do_clear();

        run_pixel(mk_pix(3, 2, 16'h0100, 16'hABCD), 3);
        run_pixel(mk_pix(3, 2, 16'h0200, 16'h1111), 3);
        run_pixel(mk_pix(3, 2, 16'h0100, 16'h2222), 3);
        run_pixel(mk_pix(3, 2, 16'h00FF, 16'h1234), 3);
        run_pixel(mk_pix(8, 0, 16'h0001, 16'h3333), 3);

        // Clear and pixel arrive together: clear must win
        drive_pixel(mk_pix(1, 1, 16'h0010, 16'h5555));
        expect_clear();
        expect_pixel(mk_pix(1, 1, 16'h0010, 16'h5555));
        clr_req = 1'b1;
        bus.req_in = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        wait_done(80);
        finish_handshake(3);

        for (int i = 0; i < 60; i++) begin
            run_pixel(mk_pix(int'($urandom_range(0, 9)), int'($urandom_range(0, 5)),
                             int'($urandom_range(0, 63)), int'($urandom)),
                      int'($urandom_range(0, 4)));
        end

        // Reset while a passing pixel is in its compare cycle
        do_clear();
        drive_pixel(mk_pix(5, 1, 16'h0001, 16'hBEEF));
        exp_rd.push_back(13);
        bus.req_in = 1'b1;
        @(negedge clk);
        check("ack_before_abort", 64'(bus.ack_in), 64'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_in = 1'b0;
        m_pass = '0;
        m_fail = '0;
        @(negedge clk);
        check("abort_ack_busy", {62'h0, bus.ack_in, busy}, 64'h0);
        check("abort_mem", {30'h0, bus.mem_en, bus.mem_we, bus.mem_wdata}, 64'h0);
        check("abort_addr", 64'(bus.mem_addr), 64'h0);
        check("abort_counters", {32'h0, pass_cnt, fail_cnt}, 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        check("reads_consumed", 64'(exp_rd.size()), 64'h0);
        check("writes_consumed", 64'(exp_wr.size()), 64'h0);
        check("clr_done_pulses", 64'(done_pulses), 64'(exp_done));
        mism = 0;
        for (int i = 0; i < c_NPIX; i++) if (ram[i] !== model_mem[i]) mism++;
        check("ram_contents", 64'(mism), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
